pc_fetch_ctrl: RTL
==================

PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 The parameter list SHALL include: RESET_PC, default 32'h0000_0000, fetch address loaded by reset.
REQ-002 The parameter list SHALL include: TRAP_VEC, default 32'h0000_0100, trap target; used only under PC_TRAP_EN.
REQ-003 Port: clk  in  1  sole clock; all state updates on posedge clk.
REQ-004 Port: rst  in  1  reset; synchronous, active-high.
REQ-005 Port: stall  in  1  decode not ready; the fetch slot is consumed only when if_valid=1 and stall=0.
REQ-006 Port: redirect_valid  in  1  branch/jump taken; one-cycle pulse.
REQ-007 Port: redirect_pc  in  32  redirect target; bits [1:0] are ignored and treated as 0.
REQ-008 Port: trap  in  1  exception pulse; present only under PC_TRAP_EN.
REQ-009 Port: imem_req  out  1  instruction fetch request; held high until imem_ack.
REQ-010 Port: imem_addr  out  32  fetch address; stable while imem_req=1 and imem_ack=0.
REQ-011 Port: imem_ack  in  1  memory returns imem_rdata this cycle; ignored when imem_req=0.
REQ-012 Port: imem_rdata  in  32  fetched instruction word.
REQ-013 Port: if_valid  out  1  fetch slot holds an instruction.
REQ-014 Port: if_pc  out  32  PC of the slot instruction.
REQ-015 Port: if_instr  out  32  slot instruction word.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, FETCH and FULL; imem_req=1 exactly in FETCH; imem_addr=pc.
REQ-017 In IDLE, the FSM SHALL go to FETCH on the next cycle.
REQ-018 In FETCH, on imem_ack with no kill, the block SHALL load if_pc<=pc, load if_instr<=imem_rdata, set if_valid<=1, set pc<=pc+4 and go to FULL.
REQ-019 In FULL, when stall=0 and there is no kill, the block SHALL clear if_valid next cycle and go to FETCH; if stall=1 it SHALL stay in FULL, holding if_valid, if_pc and if_instr unchanged.
REQ-020 A kill SHALL be redirect_valid=1, a pending redirect, or (under PC_TRAP_EN) trap=1.
REQ-021 On a kill in FULL, the block SHALL clear if_valid, set pc to the target and go to FETCH, regardless of stall.
REQ-022 On a kill in FETCH with imem_ack in the same cycle, the block SHALL drop the returned data (if_valid stays 0), set pc to the target and stay in FETCH; the new address is presented the next cycle.
REQ-023 On a kill in FETCH without imem_ack, the block SHALL latch pend<=1 and pend_pc<=target, and SHALL keep imem_addr unchanged; on the later ack it SHALL drop the data, set pc<=pend_pc, clear pend and stay in FETCH.
REQ-024 A newer redirect arriving while pend=1 SHALL overwrite pend_pc.
REQ-025 Redirects in IDLE SHALL set pc to the target.
REQ-026 Kill priority SHALL be trap > redirect_valid > pending redirect.
REQ-027 pc+4 SHALL wrap modulo 2^32, so 32'hFFFF_FFFC -> 32'h0000_0000; pc[1:0] SHALL always be 0.
REQ-028 Steady-state throughput SHALL be one instruction per (memory latency + 2) cycles; no more than one request SHALL be outstanding.

Reset
REQ-029 When rst=1 at posedge clk, the block SHALL set state<=IDLE, pc<=RESET_PC, pend<=0, pend_pc<=0, if_valid<=0, if_pc<=0 and if_instr<=0.
REQ-030 imem_req SHALL be 0 during reset and in the first cycle after reset.
REQ-031 Reset asserted mid-request SHALL abandon the outstanding fetch, and any late imem_ack SHALL be ignored because imem_req=0.
REQ-032 rst SHALL override every other input.

Configuration
REQ-033 The block SHALL support the macro PC_TRAP_EN.
REQ-034 With PC_TRAP_EN defined, the trap port SHALL exist, and trap=1 SHALL kill with target TRAP_VEC at the highest priority.
REQ-035 With PC_TRAP_EN undefined, the trap port SHALL be absent, TRAP_VEC SHALL be unused, and behaviour SHALL be otherwise identical.

Verification
REQ-036 Reset then one-cycle ack latency, stall=0: the bench SHALL see imem_addr sequence 0,4,8 and if_pc 0,4,8, each if_valid high for 1 cycle.
REQ-037 stall=1 for 5 cycles while if_valid=1 (if_pc=4): if_pc/if_instr SHALL hold, imem_req=0, and the next fetch SHALL be 8 after stall drops.
REQ-038 redirect_valid with redirect_pc=0x200 during FETCH, ack 3 cycles later: imem_addr SHALL hold its old value until ack, the data SHALL be dropped, and the next imem_addr SHALL be 0x200.
REQ-039 redirect_valid and trap in the same cycle as imem_ack (PC_TRAP_EN): no if_valid, next imem_addr=0x100; with PC_TRAP_EN off: next imem_addr=redirect_pc.
REQ-040 pc=0xFFFF_FFFC fetch then ack: if_pc SHALL be 0xFFFF_FFFC and the next imem_addr SHALL be 0; separately, rst mid-FETCH then ack: no if_valid, and restart SHALL be at RESET_PC.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// Instruction fetch controller: one outstanding imem request, a single fetch slot,
// and redirect/trap kill handling. Optional macro PC_TRAP_EN adds the trap port.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
`ifdef PC_TRAP_EN
  input  logic        trap,
`endif
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
);

  // state | meaning
  // IDLE  | one quiet cycle after reset, no request
  // FETCH | imem_req high at pc, waiting for imem_ack
  // FULL  | slot holds an instruction, waiting for decode to take it
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pend_q, pend_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic        valid_q, valid_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_instr_q, if_instr_d;

  logic        trap_w;
  logic        kill_ext;
  logic [31:0] ext_tgt;

`ifdef PC_TRAP_EN
  assign trap_w = trap;
`else
  assign trap_w = 1'b0;
`endif

  // trap outranks redirect; the pending redirect is consulted only in FETCH on ack
  assign kill_ext = trap_w | redirect_valid;
  assign ext_tgt  = trap_w ? (TRAP_VEC & ALIGN_MASK) : (redirect_pc & ALIGN_MASK);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    pend_pc_d  = pend_pc_q;
    valid_d    = valid_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
        if (kill_ext) pc_d = ext_tgt;
      end
      ST_FETCH: begin
        if (imem_ack) begin
          if (kill_ext) begin
            pc_d   = ext_tgt;
            pend_d = 1'b0;
          end else if (pend_q) begin
            pc_d   = pend_pc_q;
            pend_d = 1'b0;
          end else begin
            if_pc_d    = pc_q;
            if_instr_d = imem_rdata;
            valid_d    = 1'b1;
            pc_d       = pc_q + 32'd4;
            state_d    = ST_FULL;
          end
        end else if (kill_ext) begin
          // address must stay put until the in-flight request is acked
          pend_d    = 1'b1;
          pend_pc_d = ext_tgt;
        end
      end
      ST_FULL: begin
        if (kill_ext) begin
          valid_d = 1'b0;
          pc_d    = ext_tgt;
          state_d = ST_FETCH;
        end else if (!stall) begin
          valid_d = 1'b0;
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC & ALIGN_MASK;
      pend_q     <= 1'b0;
      pend_pc_q  <= 32'd0;
      valid_q    <= 1'b0;
      if_pc_q    <= 32'd0;
      if_instr_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      pend_pc_q  <= pend_pc_d;
      valid_q    <= valid_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
    end
  end

  assign imem_req  = (state_q == ST_FETCH);
  assign imem_addr = pc_q;
  assign if_valid  = valid_q;
  assign if_pc     = if_pc_q;
  assign if_instr  = if_instr_q;

endmodule
